// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
//   Shared definitions for the execute-stage divider.
//   - div_state_t : 2-bit divider FSM state type
//   - DIV_IDLE / DIV_BUSY / DIV_DONE / DIV_ZERO : FSM state encodings
//   - DIV_CYCLES  : number of shift-subtract iterations for a 32-bit divide
// -----------------------------------------------------------------------------
package div_unit_pkg;

    typedef logic [1:0] div_state_t;

    localparam logic [1:0] DIV_IDLE = 2'b00;
    localparam logic [1:0] DIV_BUSY = 2'b01;
    localparam logic [1:0] DIV_DONE = 2'b10;
    localparam logic [1:0] DIV_ZERO = 2'b11;

    localparam int DIV_CYCLES = 32;

endpackage : div_unit_pkg

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Multi-cycle radix-2 restoring divider serving DIV (signed) and DIVU
//   (unsigned). One quotient bit is produced per clock while BUSY; the signed
//   fix-up is applied as the final iteration retires, so result_o is loaded
//   on entry to DONE and ready_o pulses for that single cycle.
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   start_i    division requested (held by the stalled E stage until ready_o)
//   signed_i   1 = two's-complement divide, 0 = unsigned divide
//   opdata1_i  dividend (rs)
//   opdata2_i  divisor (rt)
//   annul_i    cancel the in-flight operation (flush / exception)
//   result_o   {remainder, quotient} = {HI, LO}, registered
//   ready_o    one-cycle pulse, result_o valid
// -----------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_CYCLES
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int               CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    // Two's-complement negate when requested; used both for taking operand
    // magnitudes and for the final sign fix-up.
    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic             neg);
        logic signed [WIDTH-1:0] sv;
        sv = signed'(v);
        return neg ? unsigned'(-sv) : v;
    endfunction

    // Magnitude of an operand; unsigned operands pass through untouched.
    // The most negative value maps to itself, which reads correctly as an
    // unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        return apply_sign(v, is_signed & v[WIDTH-1]);
    endfunction

    div_state_t       state;
    div_state_t       state_nxt;
    logic [CNT_W-1:0] counter;

    // Working registers
    logic [WIDTH-1:0] dividend_raw;   // untouched dividend, for divide-by-zero
    logic [WIDTH-1:0] quo_shift;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] rem_acc;        // partial remainder
    logic [WIDTH-1:0] divisor_mag;    // divisor magnitude
    logic             neg_quo;        // operand signs differ (signed only)
    logic             neg_rem;        // dividend negative (signed only)

    // Iteration step outputs
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
    logic             take;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] quo_final;
    logic [WIDTH-1:0] rem_final;
    logic             last_iter;

    // Shift-subtract step: bring in the next dividend bit, compare on WIDTH+1
    // bits so the shifted-out remainder MSB is not lost, subtract if it fits.
    always_comb begin
        partial   = {rem_acc, quo_shift[WIDTH-1]};
        diff      = partial - {1'b0, divisor_mag};
        take      = (partial >= {1'b0, divisor_mag});
        rem_nxt   = take ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
        quo_nxt   = {quo_shift[WIDTH-2:0], take};
        quo_final = apply_sign(quo_nxt, neg_quo);
        rem_final = apply_sign(rem_nxt, neg_rem);
        last_iter = (counter == LAST_ITER);
    end

    // Next-state logic. annul_i overrides everything, including completion.
    always_comb begin
        state_nxt = state;
        if (annul_i) begin
            state_nxt = DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start_i) begin
                        state_nxt = (opdata2_i == '0) ? DIV_ZERO : DIV_BUSY;
                    end
                end
                DIV_ZERO: state_nxt = DIV_DONE;
                DIV_BUSY: begin
                    if (last_iter) begin
                        state_nxt = DIV_DONE;
                    end
                end
                // start_i seen in DONE still belongs to the finishing instruction.
                DIV_DONE: state_nxt = DIV_IDLE;
                default:  state_nxt = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= DIV_IDLE;
            counter      <= '0;
            dividend_raw <= '0;
            quo_shift    <= '0;
            rem_acc      <= '0;
            divisor_mag  <= '0;
            neg_quo      <= 1'b0;
            neg_rem      <= 1'b0;
            result_o     <= '0;
            ready_o      <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_o <= 1'b0;
            if (!annul_i) begin
                case (state)
                    DIV_IDLE: begin
                        if (start_i) begin
                            dividend_raw <= opdata1_i;
                            quo_shift    <= magnitude(opdata1_i, signed_i);
                            divisor_mag  <= magnitude(opdata2_i, signed_i);
                            rem_acc      <= '0;
                            counter      <= '0;
                            neg_quo      <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                            neg_rem      <= signed_i & opdata1_i[WIDTH-1];
                        end
                    end
                    DIV_ZERO: begin
                        // Raw dividend as remainder, all-ones quotient, no sign fix.
                        result_o <= {dividend_raw, {WIDTH{1'b1}}};
                        ready_o  <= 1'b1;
                    end
                    DIV_BUSY: begin
                        rem_acc   <= rem_nxt;
                        quo_shift <= quo_nxt;
                        counter   <= counter + 1'b1;
                        if (last_iter) begin
                            result_o <= {rem_final, quo_final};
                            ready_o  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule : div_unit
